// File: rtl/spi_master.sv
// spi_master: memory-mapped SPI master on the picorv32 native bus.
// 8-bit full-duplex MSB-first transfers, programmable SCLK half-period
// (DIV+1 clk cycles), CPOL/CPHA, and a software-controlled chip select.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   spi_sel             bus select (mem_valid && address in window)
//   addr[3:0]           register offset, decoded on addr[3:2]
//   wstrb[3:0]          byte-lane write enables, 0 = read
//   spi_data_i[31:0]    write data
//   spi_ready           one-cycle access-complete pulse
//   spi_data_o[31:0]    read data, valid while spi_ready=1
//   sclk, mosi, cs_n    SPI outputs
//   miso                SPI input, already synchronous to clk
module spi_master #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sel,
    input  logic [3:0]  addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] spi_data_i,
    output logic        spi_ready,
    output logic [31:0] spi_data_o,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam int unsigned CTRL_DIV_W = 16;
    localparam logic [1:0]  REG_CTRL   = 2'd0;
    localparam logic [1:0]  REG_DATA   = 2'd1;
    localparam logic [1:0]  REG_STATUS = 2'd2;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                 state_q;
    logic                   sel_q;
    logic                   ready_q;
    logic [31:0]            rdata_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   cpol_q;
    logic                   cpha_q;
    logic                   csn_q;
    logic                   rx_valid_q;
    logic                   overrun_q;
    logic [7:0]             rx_data_q;
    logic [7:0]             tx_q;
    logic [7:0]             rx_shift_q;
    logic [DIV_WIDTH-1:0]   cnt_q;
    logic [4:0]             edge_q;
    logic                   sclk_q;
    logic                   mosi_q;

    logic                   access;
    logic                   is_wr;
    logic [1:0]             reg_sel;
    logic                   busy;
    logic                   tick;
    logic [4:0]             edge_nxt;
    logic                   fin;
    logic                   ctrl_wr;
    logic                   cfg_wr;
    logic [CTRL_DIV_W-1:0]  div16_q;
    logic [CTRL_DIV_W-1:0]  div16_d;
    logic                   cpol_d;
    logic                   start;
    logic                   data_wr_busy;
    logic                   status_w1c;
    logic                   data_rd;
    logic [31:0]            rdata_mux;
    logic                   unused_bits;

    // An access is the first cycle of each spi_sel assertion; holding
    // spi_sel high afterwards does not re-trigger side effects.
    assign access   = spi_sel & ~sel_q;
    assign is_wr    = |wstrb;
    assign reg_sel  = addr[3:2];
    assign busy     = (state_q == XFER);
    assign tick     = busy && (cnt_q == '0);
    assign edge_nxt = edge_q + 5'd1;
    assign fin      = tick && (edge_q == 5'd15);

    assign ctrl_wr      = access && is_wr && (reg_sel == REG_CTRL);
    assign cfg_wr       = ctrl_wr && !busy;
    assign div16_q      = CTRL_DIV_W'(div_q);
    assign div16_d      = {wstrb[1] ? spi_data_i[15:8] : div16_q[15:8],
                           wstrb[0] ? spi_data_i[7:0]  : div16_q[7:0]};
    assign cpol_d       = (cfg_wr && wstrb[2]) ? spi_data_i[16] : cpol_q;
    assign start        = access && (reg_sel == REG_DATA) && wstrb[0] && !busy;
    assign data_wr_busy = access && (reg_sel == REG_DATA) && is_wr && busy;
    assign status_w1c   = access && (reg_sel == REG_STATUS) && wstrb[0] && spi_data_i[2];
    assign data_rd      = access && (reg_sel == REG_DATA) && !is_wr;

    assign unused_bits = ^{spi_data_i[31:19], addr[1:0], wstrb[3]};

    // Read data from the pre-access register values
    always_comb begin
        rdata_mux = 32'h0;
        case (reg_sel)
            REG_CTRL:   rdata_mux = {13'h0, ~csn_q, cpha_q, cpol_q, div16_q};
            REG_DATA:   rdata_mux = {24'h0, rx_data_q};
            REG_STATUS: rdata_mux = {29'h0, overrun_q, rx_valid_q, busy};
            default:    rdata_mux = 32'h0;
        endcase
    end

    // Bus interface, register file and transfer engine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            csn_q      <= 1'b1;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            rx_data_q  <= 8'h0;
            tx_q       <= 8'h0;
            rx_shift_q <= 8'h0;
            cnt_q      <= '0;
            edge_q     <= 5'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            sel_q   <= spi_sel;
            ready_q <= access;
            if (access) begin
                rdata_q <= rdata_mux;
            end

            if (cfg_wr) begin
                div_q  <= DIV_WIDTH'(div16_d);
                cpol_q <= cpol_d;
                if (wstrb[2]) begin
                    cpha_q <= spi_data_i[17];
                end
            end
            if (ctrl_wr && wstrb[2]) begin
                csn_q <= ~spi_data_i[18];
            end

            // Setting overrun takes priority over the W1C clear
            if (data_wr_busy) begin
                overrun_q <= 1'b1;
            end else if (status_w1c) begin
                overrun_q <= 1'b0;
            end

            // Completion takes priority over the read-clear
            if (fin) begin
                rx_valid_q <= 1'b1;
            end else if (data_rd) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    sclk_q <= cpol_d;
                    if (start) begin
                        state_q <= XFER;
                        cnt_q   <= div_q;
                        edge_q  <= 5'd0;
                        tx_q    <= spi_data_i[7:0];
                        if (!cpha_q) begin
                            mosi_q <= spi_data_i[7];
                        end
                    end
                end
                XFER: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end else begin
                        cnt_q  <= div_q;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_nxt;
                        if (!cpha_q) begin
                            // Mode x0: sample on odd edges, shift out on even edges
                            if (edge_nxt[0]) begin
                                rx_shift_q <= {rx_shift_q[6:0], miso};
                            end else if (edge_nxt != 5'd16) begin
                                mosi_q <= tx_q[6];
                                tx_q   <= {tx_q[6:0], 1'b0};
                            end
                        end else begin
                            // Mode x1: shift out on odd edges, sample on even edges
                            if (edge_nxt[0]) begin
                                mosi_q <= tx_q[7];
                                tx_q   <= {tx_q[6:0], 1'b0};
                            end else begin
                                rx_shift_q <= {rx_shift_q[6:0], miso};
                            end
                        end
                        if (fin) begin
                            state_q   <= IDLE;
                            rx_data_q <= cpha_q ? {rx_shift_q[6:0], miso} : rx_shift_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_ready  = ready_q;
    assign spi_data_o = rdata_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs_n       = csn_q;

endmodule
